heap_pq: RTL and testbench

Parametrised binary-heap priority queue with a valid/ready command interface and selectable min/max ordering. It succeeds the single-cycle heap block. Heap maintenance is multi-cycle: one compare/swap per clock, so timing is bounded. It also adds REPLACE, error flags and a registered pop response, and sits between producers of tagged keys and a scheduler/sorter consumer.

---
 rtl/heap_pq_pkg.sv | 22 ++
 rtl/heap_pq_cmp.sv | 14 +
 rtl/heap_pq.sv | 177 +++++++++++++++++
 tb/tb_heap_pq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/heap_pq_pkg.sv
// Shared encodings for the heap priority queue: command opcodes, sift FSM
// states and error cause codes.
package heap_pq_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR   = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SIFT_UP   = 2'd1,
    ST_SIFT_DOWN = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_PUSH_FULL  = 2'd1;
  localparam logic [1:0] ERR_TAKE_EMPTY = 2'd2;

endpackage

// File: rtl/heap_pq_cmp.sv
// Strict heap-order comparator: o_better is high when i_a must sit above i_b.
// Equal keys are never "better", so equal keys are never swapped.
module heap_pq_cmp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MIN_HEAP = 0
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_better
);

  assign o_better = (MIN_HEAP != 0) ? (i_a < i_b) : (i_a > i_b);

endmodule

// File: rtl/heap_pq.sv
// Binary-heap priority queue with valid/ready commands. Heap maintenance is
// one compare/swap per clock in SIFT_UP / SIFT_DOWN; commands are accepted in
// IDLE only.
module heap_pq
  import heap_pq_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned MIN_HEAP = 0,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              top_valid,
  output logic [DATA_W-1:0] top_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = CNT_W + 1;

  state_e              r_state;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [CNT_W-1:0]    r_count;
  logic [IW-1:0]       r_idx;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_err;

  logic                w_accept;
  logic [1:0]          w_err_cause;
  logic [IW-1:0]       w_cnt_ext, w_parent, w_l, w_r, w_c;
  logic [CNT_W-1:0]    w_last;
  logic                w_l_ok, w_r_ok, w_r_better, w_pick_r, w_swap;
  logic [DATA_W-1:0]   w_cur_key, w_par_key, w_l_key, w_r_key, w_c_key;
  logic [DATA_W-1:0]   w_cmp_a, w_cmp_b;

  // Neighbour indices and the keys stored at them; child reads are steered
  // to slot 0 when the child lies beyond the occupied range.
  always_comb begin
    w_cnt_ext = {1'b0, r_count};
    w_last    = r_count - CNT_W'(1);
    w_parent  = (r_idx == '0) ? '0 : ((r_idx - IW'(1)) >> 1);
    w_l       = {r_idx[CNT_W-1:0], 1'b1};
    w_r       = w_l + IW'(1);
    w_l_ok    = (w_l < w_cnt_ext);
    w_r_ok    = (w_r < w_cnt_ext);
    w_cur_key = r_mem[r_idx[AW-1:0]];
    w_par_key = r_mem[w_parent[AW-1:0]];
    w_l_key   = r_mem[w_l_ok ? w_l[AW-1:0] : '0];
    w_r_key   = r_mem[w_r_ok ? w_r[AW-1:0] : '0];
  end

  heap_pq_cmp #(.DATA_W(DATA_W), .MIN_HEAP(MIN_HEAP)) u_child_sel (
    .i_a      (w_r_key),
    .i_b      (w_l_key),
    .o_better (w_r_better)
  );

  // Pick the better child, then route the pair under test to the swap comparator.
  always_comb begin
    w_pick_r = w_r_ok && w_r_better;
    w_c      = w_pick_r ? w_r : w_l;
    w_c_key  = w_pick_r ? w_r_key : w_l_key;
    if (r_state == ST_SIFT_UP) begin
      w_cmp_a = w_cur_key;
      w_cmp_b = w_par_key;
    end else begin
      w_cmp_a = w_c_key;
      w_cmp_b = w_cur_key;
    end
  end

  heap_pq_cmp #(.DATA_W(DATA_W), .MIN_HEAP(MIN_HEAP)) u_swap_cmp (
    .i_a      (w_cmp_a),
    .i_b      (w_cmp_b),
    .o_better (w_swap)
  );

  // Handshake and illegal-command classification.
  always_comb begin
    w_accept    = cmd_valid && (r_state == ST_IDLE);
    w_err_cause = ERR_NONE;
    if (w_accept) begin
      if ((op_e'(cmd_op) == OP_PUSH) && (r_count == CNT_W'(DEPTH)))
        w_err_cause = ERR_PUSH_FULL;
      else if (((op_e'(cmd_op) == OP_POP) || (op_e'(cmd_op) == OP_REPLACE)) && (r_count == '0))
        w_err_cause = ERR_TAKE_EMPTY;
    end
  end

  // Command execution and the one-swap-per-cycle sift FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_idx       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_err       <= (w_err_cause != ERR_NONE);
      case (r_state)
        ST_IDLE: begin
          if (w_accept && (w_err_cause == ERR_NONE)) begin
            case (op_e'(cmd_op))
              OP_CLEAR: r_count <= '0;
              OP_PUSH: begin
                r_mem[r_count[AW-1:0]] <= cmd_data;
                r_count <= r_count + CNT_W'(1);
                r_idx   <= w_cnt_ext;
                r_state <= ST_SIFT_UP;
              end
              OP_POP: begin
                r_rsp_data  <= r_mem[0];
                r_rsp_valid <= 1'b1;
                r_mem[0]    <= r_mem[w_last[AW-1:0]];
                r_count     <= w_last;
                r_idx       <= '0;
                r_state     <= (r_count > CNT_W'(2)) ? ST_SIFT_DOWN : ST_IDLE;
              end
              OP_REPLACE: begin
                r_rsp_data  <= r_mem[0];
                r_rsp_valid <= 1'b1;
                r_mem[0]    <= cmd_data;
                r_idx       <= '0;
                r_state     <= (r_count > CNT_W'(1)) ? ST_SIFT_DOWN : ST_IDLE;
              end
              default: r_state <= ST_IDLE;
            endcase
          end
        end
        ST_SIFT_UP: begin
          if ((r_idx == '0) || !w_swap) begin
            r_state <= ST_IDLE;
          end else begin
            r_mem[r_idx[AW-1:0]]    <= w_par_key;
            r_mem[w_parent[AW-1:0]] <= w_cur_key;
            r_idx                   <= w_parent;
          end
        end
        ST_SIFT_DOWN: begin
          if (!w_l_ok || !w_swap) begin
            r_state <= ST_IDLE;
          end else begin
            r_mem[r_idx[AW-1:0]] <= w_c_key;
            r_mem[w_c[AW-1:0]]   <= w_cur_key;
            r_idx                <= w_c;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign top_valid = (r_state == ST_IDLE) && (r_count != '0);
  assign top_data  = r_mem[0];
  assign count     = r_count;
  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign err       = r_err;

endmodule

// File: tb/tb_heap_pq.sv
// Bench for heap_pq: a 16-deep max-heap (index 0) and an 8-deep min-heap
// (index 1), checked against a queue-based reference that scans for the
// extreme key.
module tb_heap_pq;

  localparam int DW = 16;
  localparam logic [1:0] CLR = 2'd0, PSH = 2'd1, POPC = 2'd2, RPL = 2'd3;

  logic clk = 1'b0;
  logic reset;
  logic [1:0]          cmd_valid;
  logic [1:0]          cmd_op;
  logic [DW-1:0]       cmd_data;
  logic [1:0]          cmd_ready, rsp_valid, top_valid, full, empty, err;
  logic [1:0][DW-1:0]  rsp_data, top_data;
  logic [4:0]          count0;
  logic [3:0]          count1;

  int checks = 0;
  int errors = 0;
  int q0[$];
  int q1[$];

  always #5 clk = ~clk;

  heap_pq #(.DATA_W(DW), .DEPTH(16), .MIN_HEAP(0)) u_max (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
    .top_valid(top_valid[0]), .top_data(top_data[0]), .count(count0),
    .full(full[0]), .empty(empty[0]), .err(err[0])
  );

  heap_pq #(.DATA_W(DW), .DEPTH(8), .MIN_HEAP(1)) u_min (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
    .top_valid(top_valid[1]), .top_data(top_data[1]), .count(count1),
    .full(full[1]), .empty(empty[1]), .err(err[1])
  );

  function automatic void check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic int cnt_of(int s);
    return (s == 0) ? int'(count0) : int'(count1);
  endfunction

  function automatic int depth_of(int s);
    return (s == 0) ? 16 : 8;
  endfunction

  // ---------------- reference model ----------------
  function automatic int msize(int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int mbest(int s);
    int b;
    b = (s == 0) ? q0[0] : q1[0];
    for (int i = 1; i < msize(s); i++) begin
      int v;
      v = (s == 0) ? q0[i] : q1[i];
      if ((s == 0) ? (v > b) : (v < b)) b = v;
    end
    return b;
  endfunction

  function automatic void mremove(int s, int v);
    for (int i = 0; i < msize(s); i++) begin
      if (((s == 0) ? q0[i] : q1[i]) == v) begin
        if (s == 0) q0.delete(i); else q1.delete(i);
        return;
      end
    end
  endfunction

  function automatic void mpush(int s, int v);
    if (s == 0) q0.push_back(v); else q1.push_back(v);
  endfunction

  function automatic void mclear(int s);
    if (s == 0) q0.delete(); else q1.delete();
  endfunction

  // ---------------- drivers ----------------
  task automatic send(input int s, input logic [1:0] op, input logic [DW-1:0] d);
    @(negedge clk);
    cmd_op       = op;
    cmd_data     = d;
    cmd_valid[s] = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid[s] = 1'b0;
  endtask

  task automatic wait_idle(input int s, output int busy);
    busy = 0;
    while (cmd_ready[s] !== 1'b1 && busy < 40) begin
      @(posedge clk);
      #1;
      busy++;
    end
    if (cmd_ready[s] !== 1'b1) check($sformatf("idle_timeout%0d", s), 0, 1);
  endtask

  task automatic model_cmd(input int s, input logic [1:0] op, input int d, output int busy);
    int sz, dep, xrd, bound;
    bit xe, xrv;
    sz = msize(s); dep = depth_of(s); bound = (s == 0) ? 5 : 4;
    xe = 1'b0; xrv = 1'b0; xrd = 0;
    case (op)
      CLR:  mclear(s);
      PSH:  if (sz == dep) xe = 1'b1; else mpush(s, d);
      POPC: if (sz == 0) xe = 1'b1;
            else begin xrv = 1'b1; xrd = mbest(s); mremove(s, xrd); end
      default: if (sz == 0) xe = 1'b1;
               else begin xrv = 1'b1; xrd = mbest(s); mremove(s, xrd); mpush(s, d); end
    endcase
    send(s, op, d[DW-1:0]);
    check($sformatf("err%0d", s), err[s], xe);
    check($sformatf("rsp_valid%0d", s), rsp_valid[s], xrv);
    if (xrv) check($sformatf("rsp_data%0d", s), rsp_data[s], xrd);
    check($sformatf("count%0d", s), cnt_of(s), msize(s));
    wait_idle(s, busy);
    check($sformatf("busy_bound%0d", s), busy <= bound, 1);
    check($sformatf("top_valid%0d", s), top_valid[s], msize(s) != 0);
    if (msize(s) != 0) check($sformatf("top_data%0d", s), top_data[s], mbest(s));
    check($sformatf("empty%0d", s), empty[s], msize(s) == 0);
    check($sformatf("full%0d", s), full[s], msize(s) == dep);
  endtask

  typedef struct {
    logic [1:0] op;
    int         d;
    bit         rv;
    int         rd;
    bit         er;
    int         cnt;
    int         top;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int busy, n;
    int s, r, d;
    logic [1:0] op;

    reset = 1'b1; cmd_valid = '0; cmd_op = CLR; cmd_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_ready", cmd_ready[k], 1);
      check("rst_empty", empty[k], 1);
      check("rst_full", full[k], 0);
      check("rst_top_valid", top_valid[k], 0);
      check("rst_count", cnt_of(k), 0);
      check("rst_rsp_valid", rsp_valid[k], 0);
      check("rst_rsp_data", rsp_data[k], 0);
      check("rst_err", err[k], 0);
      check("rst_top_data", top_data[k], 0);
    end

    // Directed max-heap vectors: push/pop order, pop-on-empty, REPLACE.
    tbl.push_back('{PSH,  5,   0, 0, 0, 1, 5});
    tbl.push_back('{PSH,  9,   0, 0, 0, 2, 9});
    tbl.push_back('{PSH,  1,   0, 0, 0, 3, 9});
    tbl.push_back('{PSH,  7,   0, 0, 0, 4, 9});
    tbl.push_back('{POPC, 0,   1, 9, 0, 3, 7});
    tbl.push_back('{POPC, 0,   1, 7, 0, 2, 5});
    tbl.push_back('{POPC, 0,   1, 5, 0, 1, 1});
    tbl.push_back('{POPC, 0,   1, 1, 0, 0, 0});
    tbl.push_back('{POPC, 0,   0, 0, 1, 0, 0});
    tbl.push_back('{PSH,  9,   0, 0, 0, 1, 9});
    tbl.push_back('{PSH,  7,   0, 0, 0, 2, 9});
    tbl.push_back('{PSH,  5,   0, 0, 0, 3, 9});
    tbl.push_back('{RPL,  6,   1, 9, 0, 3, 7});
    tbl.push_back('{RPL,  100, 1, 7, 0, 3, 100});
    tbl.push_back('{CLR,  0,   0, 0, 0, 0, 0});
    tbl.push_back('{RPL,  3,   0, 0, 1, 0, 0});
    for (int i = 0; i < tbl.size(); i++) begin
      send(0, tbl[i].op, tbl[i].d[DW-1:0]);
      check($sformatf("v%0d_err", i), err[0], tbl[i].er);
      check($sformatf("v%0d_rsp_valid", i), rsp_valid[0], tbl[i].rv);
      if (tbl[i].rv) check($sformatf("v%0d_rsp_data", i), rsp_data[0], tbl[i].rd);
      check($sformatf("v%0d_count", i), count0, tbl[i].cnt);
      wait_idle(0, busy);
      check($sformatf("v%0d_busy", i), busy <= 3, 1);
      check($sformatf("v%0d_top_valid", i), top_valid[0], tbl[i].cnt != 0);
      if (tbl[i].cnt != 0) check($sformatf("v%0d_top_data", i), top_data[0], tbl[i].top);
      check($sformatf("v%0d_empty", i), empty[0], tbl[i].cnt == 0);
    end

    // Equal keys never swap: each push leaves SIFT_UP after one cycle.
    for (int i = 0; i < 3; i++) begin
      model_cmd(0, PSH, 4, busy);
      check("dup_push_busy", busy, 1);
    end
    for (int i = 0; i < 3; i++) model_cmd(0, POPC, 0, busy);

    // Min-heap fill with descending keys, overflow push, drain ascending.
    for (int k = 80; k >= 10; k -= 10) model_cmd(1, PSH, k, busy);
    check("min_full", full[1], 1);
    check("min_top", top_data[1], 10);
    model_cmd(1, PSH, 5, busy);
    check("min_after_ovf_top", top_data[1], 10);
    for (int i = 0; i < 8; i++) begin
      model_cmd(1, POPC, 0, busy);
      check("min_drain_order", rsp_data[1], 10 * (i + 1));
    end

    // Reset in the middle of a SIFT_DOWN on a full 16-entry heap.
    for (int i = 0; i < 16; i++) model_cmd(0, PSH, $urandom_range(0, 999), busy);
    send(0, POPC, '0);
    check("mid_sift_busy", cmd_ready[0], 0);
    reset = 1'b1;
    #1;
    check("mid_rst_count", count0, 0);
    check("mid_rst_ready", cmd_ready[0], 1);
    check("mid_rst_rsp_valid", rsp_valid[0], 0);
    check("mid_rst_top_valid", top_valid[0], 0);
    mclear(0); mclear(1);
    @(negedge clk);
    reset = 1'b0;

    // CLEAR on a non-empty heap.
    for (int i = 0; i < 3; i++) model_cmd(0, PSH, 20 + i, busy);
    model_cmd(0, CLR, 0, busy);
    check("clear_empty", empty[0], 1);

    // Randomised traffic on both heaps against the reference model.
    for (n = 0; n < 300; n++) begin
      s = $urandom_range(0, 1);
      r = $urandom_range(0, 99);
      op = (r < 45) ? PSH : (r < 75) ? POPC : (r < 95) ? RPL : CLR;
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 7);
      model_cmd(s, op, d, busy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
